wb_sink: RTL and testbench
==========================

Name: wb_sink

Overview:
- Receiving end of the processor's register-writeback interface (`we`, `rwd`).
- Captures every word written back by the core into a small FIFO. Delivers the words in order to a downstream consumer (debug port, display, host bridge) over a valid/ready handshake.
- Counts the writebacks it had to drop because it was full, so the core never stalls on it.

Parameters:
- WIDTH, 15, MSB index of the writeback word; data is WIDTH+1 bits (matches `WIDTH in pu.vh).
- DLOG, 3, log2 of FIFO depth; depth = 2**DLOG entries.
- CW, 7, MSB index of the drop counter; the counter is CW+1 bits.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion synchronous to clk.
- we  in  1  writeback strobe from the core; one word per cycle in which it is high.
- rwd  in  WIDTH+1  writeback data; sampled only when we=1.
- ov  out  1  output valid; FIFO non-empty.
- od  out  WIDTH+1  output data, the oldest word; stable while ov=1 and or=0.
- or  in  1  consumer ready; a word is popped on a cycle with ov=1 and or=1.
- cnt  out  DLOG+1  current occupancy, 0..2**DLOG.
- drop  out  CW+1  number of writebacks lost to overflow, saturating.
- ovf  out  1  sticky; set by the first drop.

Behaviour:
- Reset (rst=0, any time, including mid-transfer):
  - read pointer, write pointer and cnt go to 0; drop=0; ovf=0; ov=0; od=0.
  - FIFO storage contents are don't-care.
- Push: on a rising edge with we=1 and accept=1:
  - rwd is written at the write pointer; the write pointer advances modulo 2**DLOG.
  - accept = (cnt < 2**DLOG) or pop-this-cycle.
- Pop: on a rising edge with ov=1 and or=1, the read pointer advances modulo 2**DLOG.
- Timing and ordering:
  - Latency: a word pushed at edge N is visible on od/ov after edge N (zero-bubble); the earliest pop is at edge N+1.
  - od is driven from storage at the read pointer; registered pointers, combinational read mux. od=0 when empty.
  - Order is strictly FIFO; no reordering and no duplication.
- Occupancy:
  - cnt' = cnt + push − pop.
  - Simultaneous push and pop at full: both occur, cnt stays at 2**DLOG, no drop.
  - Simultaneous push and pop at cnt=1: the old word leaves, the new word becomes od next cycle, ov stays 1.
- Pop when empty: ov=0, so or is ignored; no pointer movement; no error.
- Drop: we=1 with cnt=2**DLOG and no pop:
  - the word is discarded;
  - drop increments, saturating at all-ones and never wrapping;
  - ovf is set and held until reset.
- Pointers: DLOG-bit wrap-around; full/empty resolved by cnt, not by pointer compare.
- Flow control: no backpressure to the core; we is never ignored except by the drop rule.
- or may be driven combinationally from ov by the consumer. No combinational path from or to ov/od within the same cycle beyond the pop edge.

Optional Feature:
- Macro: WB_SINK_TS_EN.
- When defined:
  - adds a free-running cycle counter, 16 bits, reset to 0, wrapping;
  - adds port `ots` (out, 16), the counter value sampled at the push edge of the word currently on od;
  - each FIFO entry is widened to hold data+timestamp; ots=0 when empty.
- When undefined: no counter, no `ots` port, entry width WIDTH+1. All other behaviour is identical.

Test Plan:
- Reset check: hold rst=0 for 3 cycles with we=1, rwd=16'h1234 → ov=0, cnt=0, drop=0, ovf=0. Release rst; first we pulse with rwd=16'hA5A5 → next cycle ov=1, od=16'hA5A5, cnt=1.
- Ordering and wrap: or=0, push 8 words 1..8 → cnt=8. Pop all with or=1 → od sequence 1..8. Then push/pop 20 more words 9..28 → all emerge in order across pointer wrap, cnt returns to 0.
- Overflow: fill 8 words, or=0, then we=1 for 3 more cycles → cnt=8, drop=3, ovf=1. Popping yields the first 8 words only.
- Push+pop at full: cnt=8, we=1 rwd=16'h0099 and or=1 in the same cycle → cnt stays 8, drop unchanged, and 16'h0099 emerges as the 8th subsequent pop.
- Saturation and async reset: with CW=3, force 20 drops → drop=4'hF. Assert rst=0 mid-cycle without a clock edge → drop=0, ovf=0, ov=0 immediately.
- WB_SINK_TS_EN: push at cycle 5 and cycle 9 after reset release → ots=5 with the first word, then 9 after its pop.

Source files
------------

// File: rtl/wb_sink_if.sv
// Writeback-sink bus: core writeback strobe/data plus the valid/ready consumer side and status.
// Optional timestamp signal `ots` exists only when WB_SINK_TS_EN is defined.
interface wb_sink_if #(
    parameter int unsigned WIDTH = 15,
    parameter int unsigned DLOG  = 3,
    parameter int unsigned CW    = 7
);
    logic             we;
    logic [WIDTH:0]   rwd;
    logic             ov;
    logic [WIDTH:0]   od;
    logic             rdy;
    logic [DLOG:0]    cnt;
    logic [CW:0]      drop;
    logic             ovf;
`ifdef WB_SINK_TS_EN
    logic [15:0]      ots;
`endif

    // Core and consumer side.
    modport master (
        output we, rwd, rdy,
        input  ov, od, cnt, drop, ovf
`ifdef WB_SINK_TS_EN
        , input ots
`endif
    );

    // Sink side.
    modport slave (
        input  we, rwd, rdy,
        output ov, od, cnt, drop, ovf
`ifdef WB_SINK_TS_EN
        , output ots
`endif
    );
endinterface

// File: rtl/wb_sink.sv
// Writeback sink: buffers every core writeback in a 2**DLOG FIFO, drains it over valid/ready,
// and counts words dropped at full. WB_SINK_TS_EN adds a 16-bit push timestamp per entry.
module wb_sink #(
    parameter int unsigned WIDTH = 15,
    parameter int unsigned DLOG  = 3,
    parameter int unsigned CW    = 7
) (
    input  logic       clk,
    input  logic       rst,
    wb_sink_if.slave   bus
);
    localparam int unsigned DW    = WIDTH + 1;
`ifdef WB_SINK_TS_EN
    localparam int unsigned TW    = 16;
`else
    localparam int unsigned TW    = 0;
`endif
    localparam int unsigned EW    = DW + TW;
    localparam int unsigned DEPTH = 32'd1 << DLOG;
    localparam int unsigned NW    = DLOG + 1;
    localparam int unsigned KW    = CW + 1;

    logic [EW-1:0]   mem [DEPTH];
    logic [DLOG-1:0] wp_q, wp_nx;
    logic [DLOG-1:0] rp_q, rp_nx;
    logic [DLOG:0]   cnt_q, cnt_nx;
    logic            ov_q, ov_nx;
    logic [CW:0]     drop_q, drop_nx;
    logic            ovf_q, ovf_nx;

    logic            full_c;
    logic            pop_c;
    logic            push_c;
    logic            lost_c;
    logic [EW-1:0]   wdat_c;
    logic [EW-1:0]   head_c;

`ifdef WB_SINK_TS_EN
    logic [15:0]     tsc_q;

    // Free-running cycle counter used to stamp each accepted word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tsc_q <= 16'd0;
        end else begin
            tsc_q <= tsc_q + 16'd1;
        end
    end

    assign wdat_c = {tsc_q, bus.rwd};
`else
    assign wdat_c = bus.rwd;
`endif

    // Next-state: full/empty come from cnt, so a push into a full FIFO is allowed only alongside a pop.
    always_comb begin
        wp_nx   = wp_q;
        rp_nx   = rp_q;
        cnt_nx  = cnt_q;
        drop_nx = drop_q;
        ovf_nx  = ovf_q;

        full_c  = (cnt_q == NW'(DEPTH));
        pop_c   = ov_q & bus.rdy;
        push_c  = bus.we & (~full_c | pop_c);
        lost_c  = bus.we & full_c & ~pop_c;

        if (push_c) begin
            wp_nx = wp_q + DLOG'(1);
        end
        if (pop_c) begin
            rp_nx = rp_q + DLOG'(1);
        end
        cnt_nx = cnt_q + NW'(push_c) - NW'(pop_c);

        if (lost_c) begin
            ovf_nx = 1'b1;
            if (drop_q != '1) begin
                drop_nx = drop_q + KW'(1);
            end
        end

        ov_nx = (cnt_nx != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            ov_q   <= 1'b0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wp_q   <= wp_nx;
            rp_q   <= rp_nx;
            cnt_q  <= cnt_nx;
            ov_q   <= ov_nx;
            drop_q <= drop_nx;
            ovf_q  <= ovf_nx;
        end
    end

    // Storage has no reset; entries are only observed once ov says they are valid.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wp_q] <= wdat_c;
        end
    end

    assign head_c   = mem[rp_q];

    assign bus.ov   = ov_q;
    assign bus.od   = ov_q ? head_c[DW-1:0] : '0;
    assign bus.cnt  = cnt_q;
    assign bus.drop = drop_q;
    assign bus.ovf  = ovf_q;
`ifdef WB_SINK_TS_EN
    assign bus.ots  = ov_q ? head_c[EW-1:DW] : 16'd0;
`endif
endmodule

// File: tb/tb_wb_sink.sv
// Directed bench for wb_sink (WIDTH=15, DLOG=3, CW=3) with hand-computed expectations.
module tb_wb_sink;
    logic clk = 1'b0;
    logic rst;
    int unsigned total  = 0;
    int unsigned passed = 0;

    wb_sink_if #(.WIDTH(15), .DLOG(3), .CW(3)) bus ();

    wb_sink #(.WIDTH(15), .DLOG(3), .CW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b0;
        bus.we  = 1'b1;
        bus.rwd = 16'h1234;
        bus.rdy = 1'b0;

        // Reset held with writeback active.
        tick(); tick(); tick();
        chk("rst_ov",   32'(bus.ov),   32'h0);
        chk("rst_cnt",  32'(bus.cnt),  32'h0);
        chk("rst_drop", 32'(bus.drop), 32'h0);
        chk("rst_ovf",  32'(bus.ovf),  32'h0);
        chk("rst_od",   32'(bus.od),   32'h0);
        bus.we = 1'b0;
        rst    = 1'b1;
        tick();

        // First word visible the cycle after its push.
        bus.we  = 1'b1;
        bus.rwd = 16'hA5A5;
        tick();
        bus.we  = 1'b0;
        chk("first_ov",  32'(bus.ov),  32'h1);
        chk("first_od",  32'(bus.od),  32'hA5A5);
        chk("first_cnt", 32'(bus.cnt), 32'h1);
        bus.rdy = 1'b1;
        tick();
        bus.rdy = 1'b0;
        chk("pop1_cnt", 32'(bus.cnt), 32'h0);
        chk("pop1_ov",  32'(bus.ov),  32'h0);
        chk("pop1_od",  32'(bus.od),  32'h0);

        // Pop request while empty must be ignored.
        bus.rdy = 1'b1;
        tick();
        bus.rdy = 1'b0;
        chk("empty_pop_cnt", 32'(bus.cnt), 32'h0);

        // Fill with 1..8, then drain in order.
        for (int i = 1; i <= 8; i++) begin
            bus.we  = 1'b1;
            bus.rwd = 16'(i);
            tick();
        end
        bus.we = 1'b0;
        chk("fill_cnt", 32'(bus.cnt), 32'h8);
        chk("fill_ovf", 32'(bus.ovf), 32'h0);
        bus.rdy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_od", 32'(bus.od), 32'(i));
            tick();
        end
        bus.rdy = 1'b0;
        chk("drain_cnt", 32'(bus.cnt), 32'h0);

        // Streaming push+pop of 9..28 across pointer wrap; cnt=1 case keeps ov high.
        for (int i = 9; i <= 28; i++) begin
            bus.we  = 1'b1;
            bus.rwd = 16'(i);
            bus.rdy = 1'b1;
            if (i > 9) begin
                chk("stream_od", 32'(bus.od), 32'(i - 1));
                chk("stream_cnt", 32'(bus.cnt), 32'h1);
            end
            tick();
        end
        bus.we = 1'b0;
        chk("stream_last", 32'(bus.od), 32'd28);
        tick();
        bus.rdy = 1'b0;
        chk("stream_cnt0", 32'(bus.cnt), 32'h0);
        chk("stream_ov0",  32'(bus.ov),  32'h0);

        // Overflow: 8 words then 3 drops.
        for (int i = 1; i <= 8; i++) begin
            bus.we  = 1'b1;
            bus.rwd = 16'(32'h100 + i);
            tick();
        end
        for (int i = 1; i <= 3; i++) begin
            bus.rwd = 16'(32'h200 + i);
            tick();
        end
        bus.we = 1'b0;
        chk("ovf_cnt",  32'(bus.cnt),  32'h8);
        chk("ovf_drop", 32'(bus.drop), 32'h3);
        chk("ovf_flag", 32'(bus.ovf),  32'h1);

        // Push and pop together at full: no drop, cnt stays 8.
        chk("full_head", 32'(bus.od), 32'h101);
        bus.we  = 1'b1;
        bus.rwd = 16'h0099;
        bus.rdy = 1'b1;
        tick();
        bus.we  = 1'b0;
        bus.rdy = 1'b0;
        chk("pp_cnt",  32'(bus.cnt),  32'h8);
        chk("pp_drop", 32'(bus.drop), 32'h3);
        bus.rdy = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            chk("ovf_od", 32'(bus.od), 32'(32'h100 + i));
            tick();
        end
        chk("pp_od8", 32'(bus.od), 32'h0099);
        tick();
        bus.rdy = 1'b0;
        chk("ovf_empty", 32'(bus.ov), 32'h0);
        chk("ovf_held",  32'(bus.ovf), 32'h1);

        // Saturate the 4-bit drop counter.
        for (int i = 1; i <= 28; i++) begin
            bus.we  = 1'b1;
            bus.rwd = 16'(32'h300 + i);
            tick();
        end
        bus.we = 1'b0;
        chk("sat_drop", 32'(bus.drop), 32'hF);
        chk("sat_cnt",  32'(bus.cnt),  32'h8);
        chk("sat_od",   32'(bus.od),   32'h301);

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b0;
        #1;
        chk("arst_drop", 32'(bus.drop), 32'h0);
        chk("arst_ovf",  32'(bus.ovf),  32'h0);
        chk("arst_ov",   32'(bus.ov),   32'h0);
        chk("arst_cnt",  32'(bus.cnt),  32'h0);
        chk("arst_od",   32'(bus.od),   32'h0);

`ifdef WB_SINK_TS_EN
        // Timestamps: pushes on the edges where the counter reads 5 and 9.
        tick();
        rst = 1'b1;
        chk("ts_rst", 32'(bus.ots), 32'h0);
        for (int i = 0; i < 5; i++) tick();
        bus.we  = 1'b1;
        bus.rwd = 16'hBEEF;
        tick();
        bus.we  = 1'b0;
        chk("ts_first_od", 32'(bus.od),  32'hBEEF);
        chk("ts_first",    32'(bus.ots), 32'd5);
        tick(); tick(); tick();
        bus.we  = 1'b1;
        bus.rwd = 16'hCAFE;
        bus.rdy = 1'b1;
        tick();
        bus.we  = 1'b0;
        bus.rdy = 1'b0;
        chk("ts_second_od", 32'(bus.od),  32'hCAFE);
        chk("ts_second",    32'(bus.ots), 32'd9);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
